// File: rtl/dmadd_seq.sv
// dmadd_seq: command sequencer driving DMADD's clear/init/load/run phases and capturing its result.
// Optional early exit on stable dm_out is enabled by defining DMADD_SEQ_EARLY_EXIT_EN.
module dmadd_seq #(
   parameter int unsigned RUN_CYCLES    = 20,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_insn,
   input  logic [4:0]  cmd_count,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_index,
   input  logic [3:0]  in_data,
   output logic        dm_rst_n,
   output logic [1:0]  dm_insn,
   output logic [3:0]  dm_index,
   output logic [3:0]  dm_data,
   output logic        dm_load,
   output logic        dm_run,
   input  logic [11:0] dm_out,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [11:0] res_value,
   output logic        res_err
);
   localparam int unsigned CntW = $clog2(RUN_CYCLES + 1);
   localparam logic [CntW-1:0] RunLast = CntW'(RUN_CYCLES);

   typedef enum logic [2:0] {
      StIdle, StClear, StInit, StLoad, StDrain, StRun, StDone
   } state_e;

   state_e          state_q, state_d;
   logic [4:0]      remaining_q, remaining_d;
   logic [CntW-1:0] run_cnt_q, run_cnt_d;
   logic            accept, reserved, xfer, capture, early_hit, res_hs;

   assign cmd_ready = (state_q == StIdle) && !rst;
   assign in_ready  = (state_q == StLoad) && (remaining_q != 5'd0) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign reserved  = (cmd_insn == 2'b11);
   assign xfer      = in_valid && in_ready;
   assign res_hs    = (state_q == StDone) && res_ready;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      run_cnt_d   = run_cnt_q;
      capture     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               remaining_d = cmd_count;
               state_d     = reserved ? StDone : StClear;
            end
         end
         StClear: state_d = StInit;
         StInit:  state_d = (remaining_q != 5'd0) ? StLoad : StDrain;
         StLoad: begin
            if (xfer) begin
               remaining_d = remaining_q - 5'd1;
               if (remaining_q == 5'd1) state_d = StDrain;
            end
         end
         StDrain: begin
            run_cnt_d = CntW'(1);
            state_d   = StRun;
         end
         StRun: begin
            if ((run_cnt_q == RunLast) || early_hit) begin
               capture = 1'b1;
               state_d = StDone;
            end else begin
               run_cnt_d = run_cnt_q + 1'b1;
            end
         end
         StDone:  if (res_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

`ifdef DMADD_SEQ_EARLY_EXIT_EN
   localparam int unsigned StabW = $clog2(STABLE_CYCLES + 1);
   localparam logic [StabW-1:0] StabLast = StabW'(STABLE_CYCLES);

   logic [11:0]     prev_q;
   logic [StabW-1:0] stab_q, stab_d;
   logic [CntW-1:0] dbg_run_count;

   assign dbg_run_count = run_cnt_q;

   // stab counts how many consecutive run cycles have shown the current dm_out value.
   always_comb begin
      stab_d    = stab_q;
      early_hit = 1'b0;
      if (state_q == StRun) begin
         if (run_cnt_q == CntW'(1)) begin
            stab_d = StabW'(1);
         end else begin
            stab_d    = (dm_out == prev_q) ? stab_q + 1'b1 : StabW'(1);
            early_hit = (stab_d == StabLast);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 12'd0;
         stab_q <= '0;
      end else if (state_q == StRun) begin
         prev_q <= dm_out;
         stab_q <= stab_d;
      end
   end
`else
   assign early_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         remaining_q <= 5'd0;
         run_cnt_q   <= '0;
         dm_rst_n    <= 1'b0;
         dm_insn     <= 2'd0;
         dm_index    <= 4'd0;
         dm_data     <= 4'd0;
         dm_load     <= 1'b0;
         dm_run      <= 1'b0;
         res_valid   <= 1'b0;
         res_value   <= 12'd0;
         res_err     <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         run_cnt_q   <= run_cnt_d;
         dm_rst_n    <= (state_d != StClear);
         dm_load     <= xfer;
         if (xfer) begin
            dm_index <= in_index;
            dm_data  <= in_data;
         end
         // Once halted in DONE, run stays high so DMADD keeps its output stable.
         dm_run <= (state_d == StRun) || ((state_d == StDone) && dm_run);
         if (accept && !reserved) dm_insn <= cmd_insn;
         if (accept && reserved) begin
            res_value <= 12'd0;
            res_valid <= 1'b1;
            res_err   <= 1'b1;
         end else if (capture) begin
            res_value <= dm_out;
            res_valid <= 1'b1;
            res_err   <= 1'b0;
         end else if (res_hs) begin
            res_valid <= 1'b0;
            res_err   <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_dmadd_seq.sv
// Self-checking bench for dmadd_seq with a stub DMADD whose out follows a per-run-cycle pattern.
module tb_dmadd_seq;
   localparam int RUN  = 20;
   localparam int STAB = 4;

   logic        clk, rst;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_insn;
   logic [4:0]  cmd_count;
   logic        in_valid, in_ready;
   logic [3:0]  in_index, in_data;
   logic        dm_rst_n, dm_load, dm_run;
   logic [1:0]  dm_insn;
   logic [3:0]  dm_index, dm_data;
   logic [11:0] dm_out;
   logic        res_valid, res_ready, res_err;
   logic [11:0] res_value;

   dmadd_seq #(.RUN_CYCLES(RUN), .STABLE_CYCLES(STAB)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_insn(cmd_insn), .cmd_count(cmd_count),
      .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index), .in_data(in_data),
      .dm_rst_n(dm_rst_n), .dm_insn(dm_insn), .dm_index(dm_index), .dm_data(dm_data),
      .dm_load(dm_load), .dm_run(dm_run), .dm_out(dm_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value), .res_err(res_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub DMADD: during run cycle k its out is pat[k].
   logic [11:0] pat [0:63];
   int run_k = 0;
   always @(posedge clk) run_k <= dm_run ? ((run_k < 62) ? run_k + 1 : run_k) : 0;
   assign dm_out = pat[run_k + 1];

   int compared = 0;
   int failed = 0;
   int w_idx [32];
   int w_dat [32];

   logic [3:0]  got_idx[$];
   logic [3:0]  got_dat[$];
   int          o_acc_ready, o_first_run, o_runs, o_first_res, o_rst0, o_load_bad;
   int          o_insn_bad, o_cmdr_bad, o_hold_bad, o_done_cycles, o_timeout;
   logic [11:0] o_res_v;
   logic        o_res_e;

   // Run length from the rules: RUN cycles, or earlier once STAB equal outputs are seen.
   function automatic int exp_len();
      int n;
      bit same, found;
      n = RUN;
      found = 0;
`ifdef DMADD_SEQ_EARLY_EXIT_EN
      for (int k = STAB; k < RUN; k++) begin
         same = 1;
         for (int j = k - STAB + 1; j < k; j++) if (pat[j] != pat[k]) same = 0;
         if (same && !found) begin
            n = k;
            found = 1;
         end
      end
`endif
      return n;
   endfunction

   function automatic int load_mismatches(input int count);
      int bad;
      bad = 0;
      for (int i = 0; i < got_idx.size() && i < count; i++)
         if (got_idx[i] !== 4'(w_idx[i]) || got_dat[i] !== 4'(w_dat[i])) bad++;
      return bad;
   endfunction

   // Drives one command and operand stream, recording what the DUT does cycle by cycle.
   task automatic run_cmd(input logic [1:0] insn, input int count, input int gap, input int hold);
      int wi, gapc, held;
      logic xfer, xfer_prev, hs;
      logic [3:0] pidx, pdat;
      got_idx.delete();
      got_dat.delete();
      o_first_run = -1; o_first_res = -1; o_runs = 0; o_rst0 = 0; o_load_bad = 0;
      o_insn_bad = 0; o_cmdr_bad = 0; o_hold_bad = 0; o_done_cycles = 0; o_timeout = 1;
      o_res_v = 12'hx; o_res_e = 1'bx;
      @(negedge clk);
      o_acc_ready = int'(cmd_ready);
      cmd_valid = 1'b1; cmd_insn = insn; cmd_count = 5'(count);
      in_valid = 1'b0; res_ready = 1'b0;
      @(posedge clk);
      xfer_prev = 1'b0; wi = 0; gapc = 0; held = 0; pidx = 4'd0; pdat = 4'd0;
      for (int c = 1; c <= 600; c++) begin
         @(negedge clk);
         if (dm_load) begin
            got_idx.push_back(dm_index);
            got_dat.push_back(dm_data);
            if (!xfer_prev || dm_index !== pidx || dm_data !== pdat) o_load_bad++;
         end else if (xfer_prev) o_load_bad++;
         if (!dm_rst_n) o_rst0++;
         if (dm_run && !res_valid) begin
            o_runs++;
            if (o_first_run < 0) o_first_run = c;
         end
         if (insn != 2'b11 && dm_insn !== insn) o_insn_bad++;
         if (cmd_ready) o_cmdr_bad++;
         if (res_valid) begin
            o_done_cycles++;
            if (o_first_res < 0) begin
               o_first_res = c; o_res_v = res_value; o_res_e = res_err;
            end else if (res_value !== o_res_v || res_err !== o_res_e) o_hold_bad++;
            if (insn != 2'b11 && !dm_run) o_hold_bad++;
            res_ready = (held >= hold);
            held++;
         end else begin
            if (o_first_res >= 0) o_hold_bad++;
            res_ready = 1'($urandom);
         end
         if (wi < count) begin
            if (gapc < gap) begin
               in_valid = 1'b0;
               if (in_ready) gapc++;
            end else begin
               in_valid = 1'b1; in_index = 4'(w_idx[wi]); in_data = 4'(w_dat[wi]);
            end
         end else begin
            in_valid = 1'($urandom); in_index = 4'($urandom); in_data = 4'($urandom);
         end
         xfer = in_valid && in_ready;
         if (xfer) begin
            pidx = in_index; pdat = in_data;
            if (wi < count) begin
               wi++;
               gapc = 0;
            end
         end
         hs = res_valid && res_ready;
         cmd_insn = 2'($urandom); cmd_count = 5'($urandom);
         @(posedge clk);
         xfer_prev = xfer;
         if (hs) begin
            o_timeout = 0;
            break;
         end
      end
      @(negedge clk);
      cmd_valid = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; in_valid = 1'b1; res_ready = 1'b0;
      cmd_insn = 2'd0; cmd_count = 5'd0; in_index = 4'd0; in_data = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      compared++; if (cmd_ready !== 1'b0) begin failed++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
      compared++; if (in_ready !== 1'b0) begin failed++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      compared++; if ({dm_rst_n, dm_load, dm_run, dm_insn, dm_index, dm_data} !== 15'd0) begin
         failed++; $display("FAIL rst_dm_pins: got %h want 0", {dm_rst_n, dm_load, dm_run, dm_insn, dm_index, dm_data}); end
      compared++; if ({res_valid, res_err, res_value} !== 14'd0) begin
         failed++; $display("FAIL rst_result: got %h want 0", {res_valid, res_err, res_value}); end
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      compared++; if (cmd_ready !== 1'b1) begin failed++; $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready); end
      @(posedge clk); @(negedge clk);
      compared++; if (dm_rst_n !== 1'b1) begin failed++; $display("FAIL idle_dm_rst_n: got %b want 1", dm_rst_n); end
      compared++; if (res_valid !== 1'b0) begin failed++; $display("FAIL idle_res_valid: got %b want 0", res_valid); end
   endtask

   task automatic test_min_back_to_back();
      for (int i = 0; i < 64; i++) pat[i] = 12'($urandom);
      w_idx[0] = 5; w_dat[0] = 0; w_idx[1] = 9; w_dat[1] = 0;
      run_cmd(2'b00, 2, 0, 0);
      compared++; if (got_idx.size() != 2) begin failed++; $display("FAIL min_loads: got %0d want 2", got_idx.size()); end
      compared++; if (load_mismatches(2) != 0 || o_load_bad != 0) begin
         failed++; $display("FAIL min_load_words: got %0d bad words, %0d bad timing want 0", load_mismatches(2), o_load_bad); end
      compared++; if (o_runs != exp_len()) begin failed++; $display("FAIL min_run_len: got %0d want %0d", o_runs, exp_len()); end
      compared++; if (o_first_run != 6) begin failed++; $display("FAIL min_latency: got %0d want 6", o_first_run); end
      compared++; if (o_res_v !== pat[exp_len()] || o_res_e !== 1'b0) begin
         failed++; $display("FAIL min_result: got %0d/%b want %0d/0", o_res_v, o_res_e, pat[exp_len()]); end
      compared++; if (o_rst0 != 1 || o_insn_bad != 0 || o_timeout != 0) begin
         failed++; $display("FAIL min_ctrl: got rst0=%0d insn_bad=%0d timeout=%0d want 1/0/0", o_rst0, o_insn_bad, o_timeout); end
   endtask

   task automatic test_madd_ramp();
      int want_len;
`ifdef DMADD_SEQ_EARLY_EXIT_EN
      want_len = 11;
`else
      want_len = RUN;
`endif
      pat[0] = 12'd0;
      for (int i = 1; i < 64; i++) pat[i] = 12'((i - 1 < 7) ? i - 1 : 7);
      for (int i = 0; i < 3; i++) begin w_idx[i] = $urandom_range(0, 15); w_dat[i] = $urandom_range(0, 15); end
      run_cmd(2'b10, 3, 0, 0);
      compared++; if (o_runs != want_len) begin failed++; $display("FAIL ramp_run_len: got %0d want %0d", o_runs, want_len); end
      compared++; if (o_res_v !== 12'd7) begin failed++; $display("FAIL ramp_result: got %0d want 7", o_res_v); end
      compared++; if (o_first_res != o_first_run + want_len) begin
         failed++; $display("FAIL ramp_capture_cycle: got %0d want %0d", o_first_res, o_first_run + want_len); end
   endtask

   task automatic test_gaps();
      for (int i = 0; i < 64; i++) pat[i] = 12'($urandom);
      for (int i = 0; i < 4; i++) begin w_idx[i] = $urandom_range(0, 15); w_dat[i] = $urandom_range(0, 15); end
      run_cmd(2'b01, 4, 2, 0);
      compared++; if (got_idx.size() != 4) begin failed++; $display("FAIL gap_loads: got %0d want 4", got_idx.size()); end
      compared++; if (load_mismatches(4) != 0 || o_load_bad != 0) begin
         failed++; $display("FAIL gap_load_words: got %0d bad words, %0d bad timing want 0", load_mismatches(4), o_load_bad); end
      compared++; if (o_first_run != 4 + 4 * 3) begin failed++; $display("FAIL gap_latency: got %0d want 16", o_first_run); end
   endtask

   task automatic test_count_zero();
      for (int i = 0; i < 64; i++) pat[i] = 12'($urandom);
      run_cmd(2'b10, 0, 0, 0);
      compared++; if (got_idx.size() != 0) begin failed++; $display("FAIL zero_loads: got %0d want 0", got_idx.size()); end
      compared++; if (o_first_run != 4) begin failed++; $display("FAIL zero_latency: got %0d want 4", o_first_run); end
      compared++; if (o_res_v !== pat[exp_len()]) begin
         failed++; $display("FAIL zero_result: got %0d want %0d", o_res_v, pat[exp_len()]); end
   endtask

   task automatic test_reserved();
      for (int i = 0; i < 3; i++) begin w_idx[i] = i; w_dat[i] = i; end
      run_cmd(2'b11, 3, 0, 0);
      compared++; if (o_first_res != 1) begin failed++; $display("FAIL rsv_res_cycle: got %0d want 1", o_first_res); end
      compared++; if (o_res_e !== 1'b1 || o_res_v !== 12'd0) begin
         failed++; $display("FAIL rsv_result: got err=%b val=%0d want 1/0", o_res_e, o_res_v); end
      compared++; if (o_rst0 != 0 || got_idx.size() != 0 || o_runs != 0) begin
         failed++; $display("FAIL rsv_untouched: got rst0=%0d loads=%0d runs=%0d want 0/0/0", o_rst0, got_idx.size(), o_runs); end
      @(negedge clk);
      compared++; if (res_err !== 1'b0 || res_valid !== 1'b0) begin
         failed++; $display("FAIL rsv_clear: got err=%b valid=%b want 0/0", res_err, res_valid); end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 64; i++) pat[i] = 12'($urandom);
      w_idx[0] = 3; w_dat[0] = 12;
      run_cmd(2'b00, 1, 0, 10);
      compared++; if (o_done_cycles != 11) begin failed++; $display("FAIL hold_cycles: got %0d want 11", o_done_cycles); end
      compared++; if (o_hold_bad != 0 || o_cmdr_bad != 0) begin
         failed++; $display("FAIL hold_stable: got hold_bad=%0d cmd_ready_seen=%0d want 0/0", o_hold_bad, o_cmdr_bad); end
      run_cmd(2'b01, 0, 0, 0);
      compared++; if (o_acc_ready != 1 || o_timeout != 0) begin
         failed++; $display("FAIL hold_next_cmd: got ready=%0d timeout=%0d want 1/0", o_acc_ready, o_timeout); end
   endtask

   task automatic test_random();
      logic [1:0] insn;
      int count, gap, hold, lat;
      for (int t = 0; t < 8; t++) begin
         insn = 2'($urandom_range(0, 3));
         count = $urandom_range(0, 31); gap = $urandom_range(0, 2); hold = $urandom_range(0, 3);
         for (int i = 0; i < 64; i++) pat[i] = 12'($urandom_range(0, 3));
         for (int i = 0; i < 32; i++) begin w_idx[i] = $urandom_range(0, 15); w_dat[i] = $urandom_range(0, 15); end
         run_cmd(insn, count, gap, hold);
         compared++; if (o_timeout != 0 || o_acc_ready != 1) begin
            failed++; $display("FAIL rnd%0d_handshake: got timeout=%0d ready=%0d want 0/1", t, o_timeout, o_acc_ready); end
         compared++; if (o_hold_bad != 0 || o_cmdr_bad != 0 || o_insn_bad != 0) begin
            failed++; $display("FAIL rnd%0d_stable: got %0d/%0d/%0d want 0/0/0", t, o_hold_bad, o_cmdr_bad, o_insn_bad); end
         if (insn == 2'b11) begin
            compared++; if (o_res_e !== 1'b1 || o_first_res != 1 || got_idx.size() != 0) begin
               failed++; $display("FAIL rnd%0d_rsv: got err=%b cyc=%0d loads=%0d want 1/1/0", t, o_res_e, o_first_res, got_idx.size()); end
         end else begin
            lat = 4 + count * (1 + gap);
            compared++; if (got_idx.size() != count || load_mismatches(count) != 0 || o_load_bad != 0) begin
               failed++; $display("FAIL rnd%0d_loads: got %0d loads %0d bad want %0d loads 0 bad", t, got_idx.size(),
                                  load_mismatches(count) + o_load_bad, count); end
            compared++; if (o_first_run != lat || o_runs != exp_len()) begin
               failed++; $display("FAIL rnd%0d_timing: got start=%0d len=%0d want %0d/%0d", t, o_first_run, o_runs, lat, exp_len()); end
            compared++; if (o_res_v !== pat[exp_len()] || o_res_e !== 1'b0) begin
               failed++; $display("FAIL rnd%0d_result: got %0d/%b want %0d/0", t, o_res_v, o_res_e, pat[exp_len()]); end
         end
      end
   endtask

   task automatic test_reset_midrun();
      bit seen;
      seen = 0;
      for (int i = 0; i < 64; i++) pat[i] = 12'($urandom);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_insn = 2'b10; cmd_count = 5'd1;
      in_valid = 1'b1; in_index = 4'd7; in_data = 4'd2;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(posedge clk); @(negedge clk);
         if (dm_run) seen = 1;
      end
      in_valid = 1'b0;
      compared++; if (!seen) begin failed++; $display("FAIL mid_run_start: got no dm_run within 50 cycles want dm_run"); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      compared++; if (dm_run !== 1'b0 || res_valid !== 1'b0) begin
         failed++; $display("FAIL mid_rst_abort: got run=%b valid=%b want 0/0", dm_run, res_valid); end
      compared++; if (cmd_ready !== 1'b0 || in_ready !== 1'b0) begin
         failed++; $display("FAIL mid_rst_ready: got cmd=%b in=%b want 0/0", cmd_ready, in_ready); end
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      compared++; if (cmd_ready !== 1'b1 || res_value !== 12'd0) begin
         failed++; $display("FAIL mid_rst_idle: got ready=%b value=%0d want 1/0", cmd_ready, res_value); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) pat[i] = 12'd0;
      test_reset();
      test_min_back_to_back();
      test_madd_ramp();
      test_gaps();
      test_count_zero();
      test_reserved();
      test_hold();
      test_random();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end
endmodule

// File: doc/dmadd_seq.md
Name: dmadd_seq

Overview:
- Upstream command sequencer for the DMADD delta-arithmetic unit (MIN / MAX / MADD over a 16-entry operand memory).
- Accepts one command (insn plus operand count), then streams {index, data} operand words into DMADD's load port.
- Drives the DMADD reset / init / run phases and captures DMADD's 12-bit out as a result on a valid/ready port.
- Sits between the host-side operand stream and the DMADD instance; it is the only driver of DMADD's control pins.

Parameters:
- RUN_CYCLES, 20, number of cycles dm_run is held high before result capture (must exceed 16 plus margin).
- STABLE_CYCLES, 4, consecutive unchanged dm_out cycles needed for early exit (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE and not in reset
- cmd_insn  in  2  00 MIN, 01 MAX, 10 MADD, 11 reserved
- cmd_count  in  5  number of operand words to load (0..31; repeated indices legal)
- in_valid  in  1  operand word offered
- in_ready  out  1  high in LOAD while remaining > 0
- in_index  in  4  operand index
- in_data  in  4  operand data
- dm_rst_n  out  1  DMADD rst_n (registered)
- dm_insn  out  2  DMADD insn (registered)
- dm_index  out  4  DMADD index (registered)
- dm_data  out  4  DMADD data (registered)
- dm_load  out  1  DMADD load (registered)
- dm_run  out  1  DMADD run (registered)
- dm_out  in  12  DMADD out
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_value  out  12  captured dm_out
- res_err  out  1  set when cmd_insn was 11

Behaviour:
- Reset values: state IDLE; dm_rst_n=0; dm_insn, dm_index, dm_data = 0; dm_load=0; dm_run=0; res_valid=0; res_value=0; res_err=0; remaining=0.
- While rst is high, cmd_ready and in_ready are forced 0. Reset mid-operation aborts everything and returns to IDLE; any pending result is discarded.
- IDLE:
  - dm_rst_n=1.
  - On cmd_valid && cmd_ready: latch dm_insn<=cmd_insn and remaining<=cmd_count, then go to CLEAR.
  - Reserved insn 11: go directly to DONE with res_value=0 and res_err=1; DMADD is not touched.
- CLEAR (1 cycle): dm_rst_n=0, which clears DMADD's i, count and total.
- INIT (1 cycle):
  - dm_rst_n=1, dm_load=0, dm_run=0; DMADD performs its per-insn initialise.
  - Next state is LOAD if remaining>0, otherwise DRAIN.
- LOAD:
  - Each in_valid && in_ready transfer at edge N drives dm_load=1 with dm_index/dm_data = the word during cycle N+1, and decrements remaining.
  - Cycles without a transfer drive dm_load=0. Gaps are legal: DMADD re-initialises, and its memory is retained.
  - The final transfer moves the FSM to DRAIN.
- DRAIN (1 cycle): carries the final word's dm_load=1 (0 if the count was 0); dm_run=0.
- RUN:
  - dm_run=1 and dm_load=0; the run counter counts 1..RUN_CYCLES.
  - At the edge ending run cycle RUN_CYCLES: res_value<=dm_out, res_valid<=1, go to DONE.
- DONE:
  - dm_run is held 1 so the halted DMADD keeps out stable.
  - res_valid holds until res_ready. On the handshake edge: res_valid<=0, res_err<=0, dm_run<=0, go to IDLE.
  - res_value holds its value until overwritten by the next capture.
- Command-to-first-run latency: 3 cycles plus load cycles. dm_insn never changes between command acceptance and return to IDLE.
- in_valid/in_index/in_data outside LOAD are ignored. cmd_valid outside IDLE is ignored; no queueing.
- DMADD's operand memory is not cleared by this block. Callers issuing MIN/MAX after earlier commands accept stale entries.

Optional Feature:
- Macro DMADD_SEQ_EARLY_EXIT_EN.
- When defined:
  - RUN also ends once dm_out has been unchanged for STABLE_CYCLES consecutive run cycles, counted from run cycle 2, whichever comes first.
  - Captured res_value is the stable dm_out.
  - A run-cycle counter value is exposed internally for debug.
- When undefined: RUN always lasts exactly RUN_CYCLES cycles, with no comparator logic.

Test Plan:
- Reset then IDLE → cmd_ready=1, dm_rst_n=1, res_valid=0. Assert rst during RUN → next cycle state IDLE, dm_run=0, res_valid=0.
- Command MIN, count=2, words {5,0},{9,0} back-to-back, real DMADD attached → dm_load high 2 cycles with index 5 then 9; dm_run high 20 cycles; res_value=12'd5, res_valid=1.
- Command MADD, count=3, stub dm_out ramps 0..7 then holds 7 → res_value=7 after exactly 20 run cycles. With DMADD_SEQ_EARLY_EXIT_EN, capture occurs on run cycle 11.
- Operand stream with 2-cycle in_valid gaps, count=4 → exactly 4 dm_load pulses, each with matching index/data one cycle after its transfer; dm_load=0 during the gaps.
- count=0 → CLEAR, INIT, DRAIN, then RUN with no dm_load pulse. Insn 11 → res_valid the cycle after accept, res_err=1, dm_rst_n never 0.
- res_ready held low 10 cycles in DONE → res_valid and res_value stable, cmd_ready=0, dm_run=1. A new cmd_valid is accepted only after the handshake.
